uart_status_transmitter: RTL and testbench

UART_STATUS_TRANSMITTER -- requirements
Module: uart_status_transmitter

---
 rtl/uart_status_transmitter.sv | 208 ++++++++++++++++++++
 tb/tb_uart_status_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_transmitter.sv
// 8N1 UART message sender: "ok\n" acknowledge and, with TEMP_REPORT_EN defined,
// a "T:hhh B:bbb\n" temperature report. One pending flag per message type.
module uart_status_transmitter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock50MHz,
  input  logic       i_Reset,
  input  logic       i_MotionDone,
  input  logic       i_ReportTemp,
  input  logic [7:0] i_HotTemp,
  input  logic [7:0] i_BedTemp,
  output logic       o_TX,
  output logic       o_Busy,
  output logic       o_MsgDone
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_pend_q, ack_pend_d;
  logic          tmp_pend;
  logic          baud_tick;
  logic [7:0]    ack_byte, cur_byte;
  logic [3:0]    last_idx;

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    case (byte_q)
      4'd0:    ack_byte = 8'h6F;
      4'd1:    ack_byte = 8'h6B;
      default: ack_byte = 8'h0A;
    endcase
  end

`ifdef TEMP_REPORT_EN
  logic        tmp_pend_q, tmp_pend_d;
  logic        sel_tmp_q, sel_tmp_d;
  logic [7:0]  hot_q, hot_d, bed_q, bed_d;
  logic [23:0] hot_asc, bed_asc;
  logic [7:0]  tmp_byte;

  function automatic logic [23:0] to_ascii(input logic [7:0] v);
    logic [7:0] h, t, o;
    h = v / 8'd100;
    t = (v / 8'd10) % 8'd10;
    o = v % 8'd10;
    return {8'h30 + h, 8'h30 + t, 8'h30 + o};
  endfunction

  assign hot_asc  = to_ascii(hot_q);
  assign bed_asc  = to_ascii(bed_q);
  assign tmp_pend = tmp_pend_q;

  always_comb begin
    case (byte_q)
      4'd0:    tmp_byte = 8'h54;
      4'd1:    tmp_byte = 8'h3A;
      4'd2:    tmp_byte = hot_asc[23:16];
      4'd3:    tmp_byte = hot_asc[15:8];
      4'd4:    tmp_byte = hot_asc[7:0];
      4'd5:    tmp_byte = 8'h20;
      4'd6:    tmp_byte = 8'h42;
      4'd7:    tmp_byte = 8'h3A;
      4'd8:    tmp_byte = bed_asc[23:16];
      4'd9:    tmp_byte = bed_asc[15:8];
      4'd10:   tmp_byte = bed_asc[7:0];
      default: tmp_byte = 8'h0A;
    endcase
  end

  assign cur_byte = sel_tmp_q ? tmp_byte : ack_byte;
  assign last_idx = sel_tmp_q ? 4'd11 : 4'd2;

  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset) begin
      tmp_pend_q <= 1'b0;
      sel_tmp_q  <= 1'b0;
      hot_q      <= '0;
      bed_q      <= '0;
    end else begin
      tmp_pend_q <= tmp_pend_d;
      sel_tmp_q  <= sel_tmp_d;
      hot_q      <= hot_d;
      bed_q      <= bed_d;
    end
  end
`else
  logic unused_temp_inputs;
  assign unused_temp_inputs = ^{i_ReportTemp, i_HotTemp, i_BedTemp};
  assign tmp_pend = 1'b0;
  assign cur_byte = ack_byte;
  assign last_idx = 4'd2;
`endif

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    done_d     = 1'b0;
    ack_pend_d = ack_pend_q | i_MotionDone;
`ifdef TEMP_REPORT_EN
    tmp_pend_d = tmp_pend_q | i_ReportTemp;
    sel_tmp_d  = sel_tmp_q;
    hot_d      = hot_q;
    bed_d      = bed_q;
`endif
    case (state_q)
      IDLE: begin
        if (ack_pend_q || tmp_pend) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          // Acknowledge wins; a request in the start cycle re-arms its flag.
          if (ack_pend_q) begin
            ack_pend_d = i_MotionDone;
`ifdef TEMP_REPORT_EN
            sel_tmp_d  = 1'b0;
`endif
          end else begin
`ifdef TEMP_REPORT_EN
            tmp_pend_d = i_ReportTemp;
            sel_tmp_d  = 1'b1;
            hot_d      = i_HotTemp;
            bed_d      = i_BedTemp;
`endif
          end
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          baud_d  = '0;
          sh_d    = cur_byte;
        end else baud_d = baud_q + 1'b1;
      end
      DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + 1'b1;
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          bit_d  = '0;
          if (byte_q == last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 4'd1;
          end
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the next state so o_TX is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  assign o_TX      = tx_q;
  assign o_Busy    = busy_q;
  assign o_MsgDone = done_q;
endmodule

// File: tb/tb_uart_status_transmitter.sv
// Directed bench for uart_status_transmitter: a serial-line receiver pops expected
// bytes from a scoreboard queue; busy/done timing checked per message.
module tb_uart_status_transmitter;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       md = 1'b0, rt = 1'b0;
  logic [7:0] hot = '0, bed = '0;
  logic       tx, busy, mdone;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  uart_status_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock50MHz(clk), .i_Reset(rst), .i_MotionDone(md), .i_ReportTemp(rt),
    .i_HotTemp(hot), .i_BedTemp(bed), .o_TX(tx), .o_Busy(busy), .o_MsgDone(mdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ack();
    exp_q.push_back(8'h6F); exp_q.push_back(8'h6B); exp_q.push_back(8'h0A);
  endtask

  // "T:205 B:007\n"
  task automatic push_temp_205_7();
    logic [7:0] m [12];
    m = '{8'h54, 8'h3A, 8'h32, 8'h30, 8'h35, 8'h20, 8'h42, 8'h3A, 8'h30, 8'h30, 8'h37, 8'h0A};
    for (int i = 0; i < 12; i++) exp_q.push_back(m[i]);
  endtask

  // Serial receiver: start detected on a negedge, then one sample per bit period.
  initial begin : mon
    int cnt;
    logic act;
    logic [7:0] sh;
    act = 1'b0; cnt = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if (!act) begin
        if (tx === 1'b0) begin act = 1'b1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt % CPB == 0) begin
          if (cnt / CPB <= 8) sh = {tx, sh[7:1]};
          else begin
            chk("stop_bit", {31'd0, tx}, 32'd1);
            n_cmp++;
            assert (exp_q.size() > 0) else begin
              n_bad++;
              $error("FAIL unexpected_byte: observed %02h expected none", sh);
            end
            if (exp_q.size() > 0) chk("rx_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
            act = 1'b0;
          end
        end
      end
    end
  end

  task automatic pulse(input logic m, input logic r);
    @(posedge clk); #1; md = m; rt = r;
    @(posedge clk); #1; md = 1'b0; rt = 1'b0;
  endtask

  task automatic wait_msgs(input int n, input int bound, output int bc, output int dc);
    int k;
    bc = 0; dc = 0; k = 0;
    while (dc < n && k < bound) begin
      @(negedge clk); k++;
      if (busy) bc++;
      if (mdone) dc++;
    end
    n_cmp++;
    assert (dc >= n) else begin
      n_bad++;
      $error("FAIL msg_timeout: observed %0d done pulses expected %0d", dc, n);
    end
    repeat (8) begin
      @(negedge clk);
      if (busy) bc++;
      if (mdone) dc++;
    end
  endtask

  task automatic idle_watch(input int cycles, output int bc, output int lc);
    bc = 0; lc = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy) bc++;
      if (tx !== 1'b1) lc++;
    end
  endtask

  initial begin
    int bc, dc, lc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, mdone}, 32'd0);
    rst = 1'b0;

    // Single acknowledge with start-bit latency
    push_ack();
    pulse(1'b1, 1'b0);
    chk("lat_e1_tx", {31'd0, tx}, 32'd1);
    chk("lat_e1_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("lat_e2_tx", {31'd0, tx}, 32'd0);
    chk("lat_e2_busy", {31'd0, busy}, 32'd1);
    wait_msgs(1, 300, bc, dc);
    chk("ack_busy_cycles", bc, 120);
    chk("ack_done_pulses", dc, 1);
    chk("ack_q_empty", exp_q.size(), 0);

    // Three requests during a message collapse to one more message
    push_ack(); push_ack();
    fork
      wait_msgs(2, 1000, bc, dc);
      begin
        pulse(1'b1, 1'b0);
        repeat (30) @(posedge clk);
        pulse(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        pulse(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        pulse(1'b1, 1'b0);
      end
    join
    chk("absorb_busy_cycles", bc, 240);
    chk("absorb_done_pulses", dc, 2);
    idle_watch(80, bc, lc);
    chk("absorb_no_third", bc, 0);

    // Reset during DATA of the second byte
    exp_q.push_back(8'h6F);
    pulse(1'b1, 1'b0);
    repeat (49) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, mdone}, 32'd0);
    idle_watch(100, bc, lc);
    chk("midrst_idle_busy", bc, 0);
    chk("midrst_idle_tx", lc, 0);
    chk("midrst_q_empty", exp_q.size(), 0);

    // Requests coinciding with reset are dropped
    @(posedge clk); #1; rst = 1'b1; md = 1'b1; rt = 1'b1;
    @(posedge clk); #1; rst = 1'b0; md = 1'b0; rt = 1'b0;
    idle_watch(60, bc, lc);
    chk("rstreq_busy", bc, 0);
    chk("rstreq_tx", lc, 0);

    // Both requests in one cycle
    hot = 8'd205; bed = 8'd7;
    push_ack();
`ifdef TEMP_REPORT_EN
    push_temp_205_7();
    fork
      wait_msgs(2, 1000, bc, dc);
      pulse(1'b1, 1'b1);
    join
    chk("both_busy_cycles", bc, 600);
    chk("both_done_pulses", dc, 2);
`else
    fork
      wait_msgs(1, 1000, bc, dc);
      pulse(1'b1, 1'b1);
    join
    chk("both_busy_cycles", bc, 120);
    chk("both_done_pulses", dc, 1);
`endif
    chk("both_q_empty", exp_q.size(), 0);

    // Temperature report alone; hot changes mid-message
`ifdef TEMP_REPORT_EN
    hot = 8'd205; bed = 8'd7;
    push_temp_205_7();
    fork
      wait_msgs(1, 1000, bc, dc);
      begin
        pulse(1'b0, 1'b1);
        repeat (100) @(posedge clk);
        hot = 8'd100;
      end
    join
    chk("temp_busy_cycles", bc, 480);
    chk("temp_done_pulses", dc, 1);
`else
    pulse(1'b0, 1'b1);
    idle_watch(100, bc, lc);
    chk("temp_off_busy", bc, 0);
    chk("temp_off_tx", lc, 0);
`endif
    chk("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
